// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Brief    : Opcodes, multi-cycle opcode ranges and iterative-unit FSM states
//            shared by the EX-stage ALU and its multiply/divide engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  typedef enum logic [4:0] {
    OP_NOP   = 5'h00,
    OP_ADD   = 5'h01,
    OP_AND   = 5'h02,
    OP_OR    = 5'h03,
    OP_SUB   = 5'h04,
    OP_XOR   = 5'h05,
    OP_SLL   = 5'h06,
    OP_EQ    = 5'h07,
    OP_NE    = 5'h08,
    OP_SRL   = 5'h09,
    OP_SLE   = 5'h0A,
    OP_SLTU  = 5'h0B,
    OP_SRA   = 5'h0C,
    OP_LUI   = 5'h0D,
    OP_SLT   = 5'h0E,
    OP_NOR   = 5'h0F,
    OP_MULT  = 5'h10,
    OP_MULTU = 5'h11,
    OP_DIV   = 5'h12,
    OP_DIVU  = 5'h13,
    OP_MFHI  = 5'h14,
    OP_MFLO  = 5'h15
  } alu_op_t;

  localparam logic [4:0] OP_MUL_FIRST = 5'h10;
  localparam logic [4:0] OP_MUL_LAST  = 5'h11;
  localparam logic [4:0] OP_DIV_FIRST = 5'h12;
  localparam logic [4:0] OP_DIV_LAST  = 5'h13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIN  = 2'd3
  } muldiv_state_t;

  function automatic logic isMulOp(input logic [4:0] op);
    return (op >= OP_MUL_FIRST) && (op <= OP_MUL_LAST);
  endfunction

  function automatic logic isDivOp(input logic [4:0] op);
    return (op >= OP_DIV_FIRST) && (op <= OP_DIV_LAST);
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_iter.sv
// ============================================================================
// Module   : muldiv_iter
// Brief    : Iterative radix-2 multiply / restoring divide writing HI/LO.
//            Divider is built only when ALU_DIV_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_srcA,
  input  logic [WIDTH-1:0] i_srcB,
  input  logic [4:0]       i_op,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

  muldiv_state_t      r_state;
  muldiv_state_t      w_nextState;
  logic [SHW-1:0]     r_count;
  logic [WIDTH-1:0]   r_hiAcc;
  logic [WIDTH-1:0]   r_loAcc;
  logic [WIDTH-1:0]   r_operand;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_negLo;
  logic               w_isMul;
  logic               w_isDiv;
  logic               w_accept;
  logic               w_signedOp;
  logic               w_lastStep;
  logic [WIDTH-1:0]   w_magA;
  logic [WIDTH-1:0]   w_magB;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH:0]     w_addA;
  logic [WIDTH:0]     w_addB;

  assign w_isMul = isMulOp(i_op);
`ifdef ALU_DIV_EN
  assign w_isDiv = isDivOp(i_op);
`else
  assign w_isDiv = 1'b0;
`endif
  assign w_accept   = i_start && (r_state == ST_IDLE) && (w_isMul || w_isDiv);
  assign w_signedOp = (i_op == OP_MULT) || (i_op == OP_DIV);
  assign w_magA     = (w_signedOp && i_srcA[WIDTH-1]) ? -i_srcA : i_srcA;
  assign w_magB     = (w_signedOp && i_srcB[WIDTH-1]) ? -i_srcB : i_srcB;
  assign w_lastStep = (r_count == LAST_STEP);
  assign w_prod     = r_negLo ? -{r_hiAcc, r_loAcc} : {r_hiAcc, r_loAcc};

  // One adder serves both engines: add for multiply, trial subtract for divide
`ifdef ALU_DIV_EN
  logic [WIDTH+1:0] w_sum;
  logic             w_borrow;
  logic             r_negHi;
  logic             r_isDiv;
  logic             r_divZero;
  logic [WIDTH-1:0] r_dividend;

  always_comb begin
    w_addA = {1'b0, r_hiAcc};
    w_addB = r_loAcc[0] ? {1'b0, r_operand} : '0;
    if (r_state == ST_DIV) begin
      w_addA = {r_hiAcc, r_loAcc[WIDTH-1]};
      w_addB = {1'b0, r_operand};
      w_sum  = {1'b0, w_addA} - {1'b0, w_addB};
    end else begin
      w_sum  = {1'b0, w_addA} + {1'b0, w_addB};
    end
  end
  assign w_borrow = w_sum[WIDTH+1];
`else
  logic [WIDTH:0] w_sum;

  always_comb begin
    w_addA = {1'b0, r_hiAcc};
    w_addB = r_loAcc[0] ? {1'b0, r_operand} : '0;
    w_sum  = w_addA + w_addB;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:        if (w_accept) w_nextState = w_isMul ? ST_MUL : ST_DIV;
      ST_MUL, ST_DIV: if (w_lastStep) w_nextState = ST_FIN;
      ST_FIN:         w_nextState = ST_IDLE;
      default:        w_nextState = ST_IDLE;
    endcase
  end

  // Accept cycle raises busy combinationally so the stall has no bubble
  always_comb begin
    o_busy = (r_state != ST_IDLE) || w_accept;
    o_done = (r_state == ST_FIN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count    <= '0;
      r_hiAcc    <= '0;
      r_loAcc    <= '0;
      r_operand  <= '0;
      r_negLo    <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
`ifdef ALU_DIV_EN
      r_negHi    <= 1'b0;
      r_isDiv    <= 1'b0;
      r_divZero  <= 1'b0;
      r_dividend <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_count   <= '0;
            r_hiAcc   <= '0;
            r_loAcc   <= w_magA;
            r_operand <= w_magB;
            r_negLo   <= w_signedOp && (i_srcA[WIDTH-1] ^ i_srcB[WIDTH-1]);
`ifdef ALU_DIV_EN
            r_negHi    <= w_signedOp && i_srcA[WIDTH-1];
            r_isDiv    <= w_isDiv;
            r_divZero  <= (i_srcB == '0);
            r_dividend <= i_srcA;
`endif
          end
        end
        ST_MUL: begin
          {r_hiAcc, r_loAcc} <= {w_sum[WIDTH:0], r_loAcc[WIDTH-1:1]};
          r_count            <= r_count + 1'b1;
        end
`ifdef ALU_DIV_EN
        ST_DIV: begin
          r_hiAcc <= w_borrow ? w_addA[WIDTH-1:0] : w_sum[WIDTH-1:0];
          r_loAcc <= {r_loAcc[WIDTH-2:0], ~w_borrow};
          r_count <= r_count + 1'b1;
        end
        ST_FIN: begin
          if (!r_isDiv) begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end else if (r_divZero) begin
            r_hi <= r_dividend;
            r_lo <= '1;
          end else begin
            r_hi <= r_negHi ? -r_hiAcc : r_hiAcc;
            r_lo <= r_negLo ? -r_loAcc : r_loAcc;
          end
        end
`else
        ST_FIN: begin
          r_hi <= w_prod[2*WIDTH-1:WIDTH];
          r_lo <= w_prod[WIDTH-1:0];
        end
`endif
        default: ;
      endcase
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

`default_nettype wire

// File: rtl/alu_muldiv.sv
// ============================================================================
// Module   : alu_muldiv
// Brief    : EX-stage ALU: single-cycle ops plus iterative MULT/DIV into HI/LO.
//            Define ALU_DIV_EN to build DIV/DIVU; otherwise they are NOPs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic [4:0]       ALUControlE,
  input  logic             StartE,
  output logic [WIDTH-1:0] ALUOutE,
  output logic             BusyE,
  output logic             DoneE,
  output logic [WIDTH-1:0] HiE,
  output logic [WIDTH-1:0] LoE
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_result;

  assign w_shamt = SrcBE[SHW-1:0];

  muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk     (clk),
    .reset   (reset),
    .i_srcA  (SrcAE),
    .i_srcB  (SrcBE),
    .i_op    (ALUControlE),
    .i_start (StartE),
    .o_busy  (BusyE),
    .o_done  (DoneE),
    .o_hi    (HiE),
    .o_lo    (LoE)
  );

  always_comb begin
    w_result = '0;
    case (ALUControlE)
      OP_ADD:  w_result = SrcAE + SrcBE;
      OP_AND:  w_result = SrcAE & SrcBE;
      OP_OR:   w_result = SrcAE | SrcBE;
      OP_SUB:  w_result = SrcAE - SrcBE;
      OP_XOR:  w_result = SrcAE ^ SrcBE;
      OP_SLL:  w_result = SrcAE << w_shamt;
      OP_EQ:   w_result = {{(WIDTH-1){1'b0}}, SrcAE == SrcBE};
      OP_NE:   w_result = {{(WIDTH-1){1'b0}}, SrcAE != SrcBE};
      OP_SRL:  w_result = SrcAE >> w_shamt;
      OP_SLE:  w_result = {{(WIDTH-1){1'b0}}, SrcAE <= SrcBE};
      OP_SLTU: w_result = {{(WIDTH-1){1'b0}}, SrcAE < SrcBE};
      OP_SRA:  w_result = $signed(SrcAE) >>> w_shamt;
      OP_LUI:  w_result = SrcBE << (WIDTH / 2);
      OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, $signed(SrcAE) < $signed(SrcBE)};
      OP_NOR:  w_result = ~(SrcAE | SrcBE);
      // Reads see the architectural HI/LO, i.e. stale values while busy
      OP_MFHI: w_result = HiE;
      OP_MFLO: w_result = LoE;
      default: w_result = '0;
    endcase
  end

  assign ALUOutE = w_result;

endmodule

`default_nettype wire

// File: tb/tb_alu_muldiv.sv
// ============================================================================
// Module   : tb_alu_muldiv
// Brief    : Directed self-checking bench for alu_muldiv (WIDTH=32);
//            divider checks are built when ALU_DIV_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_muldiv;
  import alu_pkg::*;

  localparam int WIDTH = 32;

  typedef struct packed {
    logic [4:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp;
  } vec_t;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] SrcAE;
  logic [WIDTH-1:0] SrcBE;
  logic [4:0]       ALUControlE;
  logic             StartE;
  logic [WIDTH-1:0] ALUOutE;
  logic             BusyE;
  logic             DoneE;
  logic [WIDTH-1:0] HiE;
  logic [WIDTH-1:0] LoE;

  int   nChecks = 0;
  int   nFails  = 0;
  vec_t vecs [20];
  int   busyN;
  int   doneN;

  alu_muldiv #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .SrcAE       (SrcAE),
    .SrcBE       (SrcBE),
    .ALUControlE (ALUControlE),
    .StartE      (StartE),
    .ALUOutE     (ALUOutE),
    .BusyE       (BusyE),
    .DoneE       (DoneE),
    .HiE         (HiE),
    .LoE         (LoE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one multi-cycle op, scramble the inputs after acceptance and count
  // busy/done cycles; poke re-issues a MULTU mid-flight that must be ignored.
  task automatic runOp(input logic [4:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input bit poke, output int nBusy, output int nDone);
    nBusy = 0;
    nDone = 0;
    ALUControlE = op;
    SrcAE       = a;
    SrcBE       = b;
    StartE      = 1'b1;
    #1;
    checkValue("acceptBusy", 64'(BusyE), 64'd1);
    @(posedge clk);
    #1;
    StartE      = 1'b0;
    SrcAE       = ~a;
    SrcBE       = b + 32'd3;
    ALUControlE = OP_ADD;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!BusyE) break;
      nBusy++;
      if (DoneE) nDone++;
      if (poke && i == 5) begin
        StartE      = 1'b1;
        ALUControlE = OP_MULTU;
        SrcAE       = 32'h7;
        SrcBE       = 32'h9;
      end
      if (poke && i == 6) StartE = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    SrcAE       = '0;
    SrcBE       = '0;
    ALUControlE = OP_NOP;
    StartE      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkValue("rstHi",   64'(HiE),   64'd0);
    checkValue("rstLo",   64'(LoE),   64'd0);
    checkValue("rstBusy", 64'(BusyE), 64'd0);
    checkValue("rstDone", 64'(DoneE), 64'd0);
    reset = 1'b0;

    vecs = '{
      '{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000},
      '{OP_SRA,  32'h80000000, 32'h0000001F, 32'hFFFFFFFF},
      '{OP_SLL,  32'h00000001, 32'h00000014, 32'h00100000},
      '{OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001},
      '{OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000},
      '{OP_SUB,  32'h00000000, 32'h00000001, 32'hFFFFFFFF},
      '{OP_SRL,  32'h80000000, 32'h0000001F, 32'h00000001},
      '{OP_LUI,  32'h00000000, 32'h00001234, 32'h12340000},
      '{OP_SLE,  32'h00000005, 32'h00000005, 32'h00000001},
      '{OP_SLE,  32'h00000006, 32'h00000005, 32'h00000000},
      '{OP_EQ,   32'h00000003, 32'h00000003, 32'h00000001},
      '{OP_NE,   32'h00000003, 32'h00000004, 32'h00000001},
      '{OP_NOR,  32'h0F0F0F0F, 32'hF0F0F0F0, 32'h00000000},
      '{OP_XOR,  32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0},
      '{OP_AND,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000},
      '{OP_OR,   32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0},
      '{OP_SLL,  32'h00000001, 32'h00000021, 32'h00000002},
      '{5'h1F,   32'h00000005, 32'h00000005, 32'h00000000},
      '{OP_SRA,  32'h40000000, 32'h0000001E, 32'h00000001},
      '{OP_SLT,  32'h00000001, 32'hFFFFFFFF, 32'h00000000}
    };
    foreach (vecs[i]) begin
      ALUControlE = vecs[i].op;
      SrcAE       = vecs[i].a;
      SrcBE       = vecs[i].b;
      StartE      = (i == 0);
      #1;
      checkValue($sformatf("op%02h_v%0d", vecs[i].op, i), 64'(ALUOutE), 64'(vecs[i].exp));
      if (i == 0) checkValue("singleNoBusy", 64'(BusyE), 64'd0);
    end
    StartE = 1'b0;

    runOp(OP_MULT, 32'hFFFFFFFE, 32'h00000003, 1'b0, busyN, doneN);
    checkValue("multBusyCycles", 64'(busyN), 64'd33);
    checkValue("multDoneCount",  64'(doneN), 64'd1);
    checkValue("multHiLo", {HiE, LoE}, 64'hFFFFFFFF_FFFFFFFA);

    runOp(OP_MULTU, 32'hFFFFFFFE, 32'h00000003, 1'b0, busyN, doneN);
    checkValue("multuBusyCycles", 64'(busyN), 64'd33);
    checkValue("multuHiLo", {HiE, LoE}, 64'h00000002_FFFFFFFA);
    ALUControlE = OP_MFHI;
    #1;
    checkValue("mfhi", 64'(ALUOutE), 64'h00000002);
    ALUControlE = OP_MFLO;
    #1;
    checkValue("mflo", 64'(ALUOutE), 64'hFFFFFFFA);

`ifdef ALU_DIV_EN
    runOp(OP_DIV, 32'hFFFFFFF9, 32'h00000002, 1'b0, busyN, doneN);
    checkValue("divBusyCycles", 64'(busyN), 64'd33);
    checkValue("divDoneCount",  64'(doneN), 64'd1);
    checkValue("divNeg", {HiE, LoE}, 64'hFFFFFFFF_FFFFFFFD);
    runOp(OP_DIVU, 32'd100, 32'd7, 1'b0, busyN, doneN);
    checkValue("divu", {HiE, LoE}, 64'h00000002_0000000E);
    runOp(OP_DIV, 32'd5, 32'd0, 1'b0, busyN, doneN);
    checkValue("divZeroBusy", 64'(busyN), 64'd33);
    checkValue("divZero", {HiE, LoE}, 64'h00000005_FFFFFFFF);
    runOp(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, busyN, doneN);
    checkValue("divOverflow", {HiE, LoE}, 64'h00000000_80000000);
`endif

    runOp(OP_MULT, 32'h00000010, 32'hFFFFFFFF, 1'b1, busyN, doneN);
    checkValue("pokeBusyCycles", 64'(busyN), 64'd33);
    checkValue("pokeDoneCount",  64'(doneN), 64'd1);
    checkValue("pokeHiLo", {HiE, LoE}, 64'hFFFFFFFF_FFFFFFF0);

`ifdef ALU_DIV_EN
    ALUControlE = OP_DIVU;
`else
    ALUControlE = OP_MULTU;
`endif
    SrcAE  = 32'd100;
    SrcBE  = 32'd7;
    StartE = 1'b1;
    @(posedge clk);
    #1;
    StartE = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    checkValue("midRstBusy", 64'(BusyE), 64'd0);
    checkValue("midRstDone", 64'(DoneE), 64'd0);
    checkValue("midRstHiLo", {HiE, LoE}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    doneN = 0;
    repeat (40) begin
      @(negedge clk);
      if (DoneE) doneN++;
    end
    checkValue("postRstNoDone", 64'(doneN), 64'd0);

    runOp(OP_MULTU, 32'h00010000, 32'h00010000, 1'b0, busyN, doneN);
    checkValue("postRstMultDone", 64'(doneN), 64'd1);
    checkValue("postRstMult", {HiE, LoE}, 64'h00000001_00000000);

    runOp(OP_MULTU, 32'h00012345, 32'h00000010, 1'b0, busyN, doneN);
    checkValue("smallMultu", {HiE, LoE}, 64'h00000000_00123450);

`ifndef ALU_DIV_EN
    ALUControlE = OP_DIV;
    SrcAE       = 32'd10;
    SrcBE       = 32'd2;
    StartE      = 1'b1;
    #1;
    checkValue("nodivAcceptBusy", 64'(BusyE), 64'd0);
    checkValue("nodivOut", 64'(ALUOutE), 64'd0);
    @(negedge clk);
    checkValue("nodivBusy", 64'(BusyE), 64'd0);
    checkValue("nodivDone", 64'(DoneE), 64'd0);
    StartE = 1'b0;
    repeat (40) @(negedge clk);
    checkValue("nodivHiLo", {HiE, LoE}, 64'h00000000_00123450);
    ALUControlE = OP_MFLO;
    #1;
    checkValue("nodivMflo", 64'(ALUOutE), 64'h00123450);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

`default_nettype wire
